// File: rtl/nonce_scanner_pkg.sv
// Shared constants and types for the nonce scanner: widths, second-block padding, FSM states.
// The helper function assembles the hasher's second-block word from the nonce and header tail.
package nonce_scanner_pkg;

    localparam int NONCE_W = 32;
    localparam int HASH_W  = 256;
    localparam int TAIL_W  = 96;
    localparam int BLOCK_W = 512;
    localparam int PAD_W   = BLOCK_W - NONCE_W - TAIL_W;

    // Fixed padding word for an 80-byte header; it sits above the nonce and tail in data1.
    localparam logic [PAD_W-1:0] SHA_PAD_384 = {32'h0000_0280, 320'h0, 32'h8000_0000};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic logic [BLOCK_W-1:0] build_data1(
        input logic [NONCE_W-1:0] nonce,
        input logic [TAIL_W-1:0]  tail
    );
        return {SHA_PAD_384, nonce, tail};
    endfunction

endpackage

// File: rtl/gn_fifo.sv
// Golden-nonce queue: synchronous FIFO, head word always visible on head_dat_o.
// Latency: a push is visible at the head one cycle later; pop takes effect at the clock edge.
// Backpressure: push while full is discarded unless a pop happens in the same cycle.
module gn_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == DEPTH_CNT);
    assign empty_o    = (count_q == '0);
    assign head_dat_o = mem_q[rd_ptr_q];

    // A pop frees the slot the concurrent push needs, so full+pop+push is lossless.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
        end
    end

endmodule

// File: rtl/nonce_scanner.sv
// Nonce scanner: feeds one nonce per clock to a free-running hasher and queues nonces whose hash2 <= target.
// Latency: winner reaches the FIFO PIPE_LATENCY+1 cycles after issue; never stalls the hasher, drops when full.
// Optional macro GN_DROP_CNT_EN adds the saturating gn_drop_cnt output.
module nonce_scanner
    import nonce_scanner_pkg::*;
#(
    parameter int                 PIPE_LATENCY = 130,
    parameter int                 FIFO_DEPTH   = 4,
    parameter logic [NONCE_W-1:0] START_NONCE  = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 work_valid,
    output logic                 work_ready,
    input  logic [HASH_W-1:0]    work_midstate,
    input  logic [TAIL_W-1:0]    work_tail,
    input  logic [HASH_W-1:0]    work_target,
    input  logic                 abort,
    output logic [HASH_W-1:0]    hash0,
    output logic [BLOCK_W-1:0]   data1,
    input  logic [HASH_W-1:0]    hash2,
    output logic                 gn_valid,
    input  logic                 gn_ready,
    output logic [NONCE_W-1:0]   gn_nonce,
    output logic                 busy,
    output logic                 done
`ifdef GN_DROP_CNT_EN
    ,
    output logic [7:0]           gn_drop_cnt
`endif
);

    state_e               state_q, state_d;
    logic [NONCE_W-1:0]   nonce_q, nonce_d;
    logic [NONCE_W-1:0]   check_nonce_q, check_nonce_d;
    logic [HASH_W-1:0]    midstate_q;
    logic [TAIL_W-1:0]    tail_q;
    logic [HASH_W-1:0]    target_q;
    logic [PIPE_LATENCY-1:0] vline_q, vline_d;
    logic                 done_q, done_d;
    logic                 res_win_q, res_win_d;
    logic [NONCE_W-1:0]   res_nonce_q, res_nonce_d;

    logic                 accept;
    logic                 abort_hit;
    logic                 chk_vld;
    logic                 chk_win;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    always_comb begin
        state_d    = state_q;
        nonce_d    = nonce_q;
        vline_d    = {vline_q[PIPE_LATENCY-2:0], 1'b0};
        done_d     = 1'b0;
        accept     = 1'b0;
        abort_hit  = 1'b0;
        work_ready = 1'b0;
        case (state_q)
            IDLE: begin
                work_ready = 1'b1;
                if (work_valid) begin
                    accept  = 1'b1;
                    nonce_d = START_NONCE;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    abort_hit = 1'b1;
                end else begin
                    vline_d[0] = 1'b1;
                    nonce_d    = nonce_q + 32'd1;
                    // All-ones is the last nonce of the space; the counter wraps but 0 is never issued.
                    if (nonce_q == '1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    abort_hit = 1'b1;
                end else if (vline_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort_hit) begin
            state_d = IDLE;
            vline_d = '0;
            done_d  = 1'b1;
        end
    end

    // hash2 in this cycle belongs to check_nonce whenever the delay line's oldest bit is set.
    assign chk_vld = vline_q[PIPE_LATENCY-1] & ~abort_hit;
    assign chk_win = (hash2 <= target_q);

    always_comb begin
        check_nonce_d = check_nonce_q;
        res_win_d     = 1'b0;
        res_nonce_d   = res_nonce_q;
        if (accept) begin
            check_nonce_d = START_NONCE;
        end else if (chk_vld) begin
            check_nonce_d = check_nonce_q + 32'd1;
            res_win_d     = chk_win;
            res_nonce_d   = check_nonce_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            nonce_q       <= '0;
            check_nonce_q <= '0;
            midstate_q    <= '0;
            tail_q        <= '0;
            target_q      <= '0;
            vline_q       <= '0;
            done_q        <= 1'b0;
            res_win_q     <= 1'b0;
            res_nonce_q   <= '0;
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            check_nonce_q <= check_nonce_d;
            vline_q       <= vline_d;
            done_q        <= done_d;
            res_win_q     <= res_win_d;
            res_nonce_q   <= res_nonce_d;
            if (accept) begin
                midstate_q <= work_midstate;
                tail_q     <= work_tail;
                target_q   <= work_target;
            end
        end
    end

    // The registered result of an aborted unit must not reach the queue.
    assign fifo_push = res_win_q & ~abort_hit;
    assign fifo_pop  = gn_valid & gn_ready;

    gn_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_gn_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i (res_nonce_q),
        .pop_i      (fifo_pop),
        .head_dat_o (gn_nonce),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign gn_valid = ~fifo_empty;
    assign hash0    = midstate_q;
    assign data1    = build_data1(nonce_q, tail_q);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

`ifdef GN_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       fifo_drop;

    assign fifo_drop = fifo_push & fifo_full & ~fifo_pop;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept) begin
            drop_cnt_d = '0;
        end else if (fifo_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign gn_drop_cnt = drop_cnt_q;
`else
    logic fifo_full_unused;
    assign fifo_full_unused = fifo_full;
`endif

endmodule

// File: tb/tb_nonce_scanner.sv
// Directed bench for nonce_scanner: main instance starts at nonce 0, second instance starts near the wrap point.
`timescale 1ns/1ps
module tb_nonce_scanner;

    localparam int L = 130;
    localparam logic [383:0] EXP_PAD = {32'h0000_0280, 320'h0, 32'h8000_0000};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         work_valid, work_ready, abort, gn_valid, gn_ready, busy, done;
    logic [255:0] work_midstate, work_target, hash0, hash2;
    logic [95:0]  work_tail;
    logic [511:0] data1;
    logic [31:0]  gn_nonce;

    logic         w_work_valid, w_work_ready, w_abort, w_gn_valid, w_gn_ready, w_busy, w_done;
    logic [255:0] w_hash0, w_hash2;
    logic [511:0] w_data1;
    logic [31:0]  w_gn_nonce;

`ifdef GN_DROP_CNT_EN
    logic [7:0] gn_drop_cnt, w_gn_drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Stub hasher: returns hash2 for the data1 nonce L cycles later; only win_nonce hashes to zero.
    logic [31:0] win_nonce;
    logic [31:0] pipe [L];
    always @(posedge clk) begin
        for (int i = L-1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= data1[127:96];
    end
    assign hash2   = (pipe[L-1] === win_nonce) ? 256'h0 : {256{1'b1}};
    assign w_hash2 = 256'h0;

    nonce_scanner #(.PIPE_LATENCY(L), .FIFO_DEPTH(4), .START_NONCE(32'h0)) dut (
        .clk(clk), .rst(rst), .work_valid(work_valid), .work_ready(work_ready),
        .work_midstate(work_midstate), .work_tail(work_tail), .work_target(work_target),
        .abort(abort), .hash0(hash0), .data1(data1), .hash2(hash2),
        .gn_valid(gn_valid), .gn_ready(gn_ready), .gn_nonce(gn_nonce), .busy(busy), .done(done)
`ifdef GN_DROP_CNT_EN
        , .gn_drop_cnt(gn_drop_cnt)
`endif
    );

    nonce_scanner #(.PIPE_LATENCY(L), .FIFO_DEPTH(4), .START_NONCE(32'hFFFF_FFFD)) u_wrap (
        .clk(clk), .rst(rst), .work_valid(w_work_valid), .work_ready(w_work_ready),
        .work_midstate(256'h0), .work_tail(96'h0), .work_target({256{1'b1}}),
        .abort(w_abort), .hash0(w_hash0), .data1(w_data1), .hash2(w_hash2),
        .gn_valid(w_gn_valid), .gn_ready(w_gn_ready), .gn_nonce(w_gn_nonce), .busy(w_busy), .done(w_done)
`ifdef GN_DROP_CNT_EN
        , .gn_drop_cnt(w_gn_drop_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        work_valid = 0; abort = 0; gn_ready = 0; work_midstate = '0; work_tail = '0; work_target = '0;
        w_work_valid = 0; w_abort = 0; w_gn_ready = 0;
        win_nonce = 32'hFFFF_0000;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_checks++; if (work_ready !== 1'b1) begin n_fail++; $display("FAIL rst_work_ready: got %b want 1", work_ready); end
        n_checks++; if (gn_valid !== 1'b0) begin n_fail++; $display("FAIL rst_gn_valid: got %b want 0", gn_valid); end
        n_checks++; if (gn_nonce !== 32'h0) begin n_fail++; $display("FAIL rst_gn_nonce: got %h want 0", gn_nonce); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (hash0 !== 256'h0) begin n_fail++; $display("FAIL rst_hash0: got %h want 0", hash0); end
        n_checks++; if (data1 !== {EXP_PAD, 128'h0}) begin n_fail++; $display("FAIL rst_data1: got %h want %h", data1, {EXP_PAD, 128'h0}); end
        n_checks++; if (w_gn_valid !== 1'b0 || w_busy !== 1'b0) begin n_fail++; $display("FAIL rst_wrap_idle: got valid=%b busy=%b want 0 0", w_gn_valid, w_busy); end
`ifdef GN_DROP_CNT_EN
        n_checks++; if (gn_drop_cnt !== 8'h0) begin n_fail++; $display("FAIL rst_drop_cnt: got %0d want 0", gn_drop_cnt); end
`endif
    endtask

    task automatic test_issue();
        logic [255:0] m;
        logic [95:0]  t;
        int  cyc;
        bit  seen;
        m = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_1111_2222_3333_4444_5555_6666_7777_8888;
        t = 96'hA5A5_5A5A_DEAD_BEEF_CAFE_F00D;
        work_midstate = m; work_tail = t; work_target = 256'h1; win_nonce = 32'd5;
        work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        n_checks++; if (work_ready !== 1'b0) begin n_fail++; $display("FAIL issue_work_ready: got %b want 0", work_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL issue_busy: got %b want 1", busy); end
        n_checks++; if (hash0 !== m) begin n_fail++; $display("FAIL issue_hash0: got %h want %h", hash0, m); end
        n_checks++; if (data1[95:0] !== t || data1[511:128] !== EXP_PAD) begin n_fail++; $display("FAIL issue_data1_fixed: got %h", data1); end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (data1[127:96] !== k) begin n_fail++; $display("FAIL issue_nonce_seq: got %h want %h", data1[127:96], k); end
            tick();
        end
        cyc = 5; seen = 0;
        while (!seen && cyc < 5 + L + 20) begin
            if (gn_valid === 1'b1) seen = 1;
            else begin tick(); cyc++; end
        end
        n_checks++; if (!seen || cyc != 5 + L + 2) begin n_fail++; $display("FAIL issue_gn_latency: got cycle %0d (seen=%0d) want %0d", cyc, seen, 5 + L + 2); end
        n_checks++; if (gn_nonce !== 32'h5) begin n_fail++; $display("FAIL issue_gn_nonce: got %h want 5", gn_nonce); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || work_ready !== 1'b1) begin n_fail++; $display("FAIL issue_abort: got done=%b busy=%b ready=%b want 1 0 1", done, busy, work_ready); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL issue_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_abort_ignored: got busy=%b done=%b want 0 0", busy, done); end
        work_midstate = 256'hBEEF; work_target = 256'h1; win_nonce = 32'd3;
        work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        n_checks++; if (hash0 !== 256'hBEEF) begin n_fail++; $display("FAIL abort_hash0: got %h want beef", hash0); end
        repeat (10) tick();
        n_checks++; if (data1[127:96] !== 32'd10) begin n_fail++; $display("FAIL abort_nonce10: got %h want a", data1[127:96]); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_done: got done=%b busy=%b want 1 0", done, busy); end
        n_checks++; if (gn_valid !== 1'b1 || gn_nonce !== 32'h5) begin n_fail++; $display("FAIL abort_retained: got valid=%b nonce=%h want 1 5", gn_valid, gn_nonce); end
        repeat (L + 10) tick();
        n_checks++; if (gn_nonce !== 32'h5) begin n_fail++; $display("FAIL abort_head_after: got %h want 5", gn_nonce); end
        gn_ready = 1'b1;
        tick();
        gn_ready = 1'b0;
        n_checks++; if (gn_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_push: got gn_valid=%b nonce=%h want empty", gn_valid, gn_nonce); end
    endtask

    task automatic test_fill();
        logic [31:0] exp_q [4];
        exp_q[0] = 32'd1; exp_q[1] = 32'd2; exp_q[2] = 32'd3; exp_q[3] = 32'd304;
        work_target = {256{1'b1}}; win_nonce = 32'hFFFF_0000;
        work_valid = 1'b1; abort = 1'b1;
        tick();
        work_valid = 1'b0; abort = 1'b0;
        n_checks++; if (busy !== 1'b1 || data1[127:96] !== 32'h0) begin n_fail++; $display("FAIL fill_accept_with_abort: got busy=%b nonce=%h want 1 0", busy, data1[127:96]); end
        repeat (L + 1) tick();
        n_checks++; if (gn_valid !== 1'b0) begin n_fail++; $display("FAIL fill_early_valid: got %b want 0", gn_valid); end
        tick();
        n_checks++; if (gn_valid !== 1'b1 || gn_nonce !== 32'h0) begin n_fail++; $display("FAIL fill_first: got valid=%b nonce=%h want 1 0", gn_valid, gn_nonce); end
        repeat (13) tick();
`ifdef GN_DROP_CNT_EN
        n_checks++; if (gn_drop_cnt !== 8'd10) begin n_fail++; $display("FAIL fill_drop_cnt10: got %0d want 10", gn_drop_cnt); end
`endif
        repeat (290) tick();
        n_checks++; if (gn_nonce !== 32'h0) begin n_fail++; $display("FAIL fill_head_kept: got %h want 0", gn_nonce); end
`ifdef GN_DROP_CNT_EN
        n_checks++; if (gn_drop_cnt !== 8'd255) begin n_fail++; $display("FAIL fill_drop_sat: got %0d want 255", gn_drop_cnt); end
`endif
        gn_ready = 1'b1;
        tick();
        gn_ready = 1'b0;
        n_checks++; if (gn_nonce !== 32'h1) begin n_fail++; $display("FAIL fill_pop_push_head: got %h want 1", gn_nonce); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL fill_abort_done: got %b want 1", done); end
`ifdef GN_DROP_CNT_EN
        n_checks++; if (gn_drop_cnt !== 8'd255) begin n_fail++; $display("FAIL fill_drop_after: got %0d want 255", gn_drop_cnt); end
`endif
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (gn_valid !== 1'b1 || gn_nonce !== exp_q[i]) begin n_fail++; $display("FAIL fill_drain_%0d: got valid=%b nonce=%h want 1 %h", i, gn_valid, gn_nonce, exp_q[i]); end
            gn_ready = 1'b1;
            tick();
            gn_ready = 1'b0;
        end
        n_checks++; if (gn_valid !== 1'b0) begin n_fail++; $display("FAIL fill_count4: got gn_valid=%b want 0", gn_valid); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_q [3];
        int cyc;
        exp_q[0] = 32'hFFFF_FFFD; exp_q[1] = 32'hFFFF_FFFE; exp_q[2] = 32'hFFFF_FFFF;
        w_work_valid = 1'b1;
        tick();
        w_work_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (w_data1[127:96] !== exp_q[k]) begin n_fail++; $display("FAIL wrap_issue_%0d: got %h want %h", k, w_data1[127:96], exp_q[k]); end
            tick();
        end
        n_checks++; if (w_busy !== 1'b1) begin n_fail++; $display("FAIL wrap_drain_busy: got %b want 1", w_busy); end
        cyc = 3;
        while (w_done !== 1'b1 && cyc < L + 20) begin tick(); cyc++; end
        n_checks++; if (w_done !== 1'b1 || cyc != L + 3) begin n_fail++; $display("FAIL wrap_done_time: got cycle %0d done=%b want %0d", cyc, w_done, L + 3); end
        tick();
        n_checks++; if (w_done !== 1'b0 || w_busy !== 1'b0 || w_work_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_idle: got done=%b busy=%b ready=%b want 0 0 1", w_done, w_busy, w_work_ready); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (w_gn_valid !== 1'b1 || w_gn_nonce !== exp_q[i]) begin n_fail++; $display("FAIL wrap_fifo_%0d: got valid=%b nonce=%h want 1 %h", i, w_gn_valid, w_gn_nonce, exp_q[i]); end
            w_gn_ready = 1'b1;
            tick();
            w_gn_ready = 1'b0;
        end
        n_checks++; if (w_gn_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_no_nonce0: got valid=%b nonce=%h want empty", w_gn_valid, w_gn_nonce); end
`ifdef GN_DROP_CNT_EN
        n_checks++; if (w_gn_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_drop_cnt: got %0d want 0", w_gn_drop_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_issue();
        test_abort();
        test_fill();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
